mpx_muldiv: RTL

MPX_MULDIV -- requirements
Module: mpx_muldiv

---
 rtl/mpx_muldiv_pkg.sv | 22 ++
 rtl/mpx_muldiv_if.sv | 24 ++
 rtl/mpx_muldiv_divider.sv | 79 +++++++
 rtl/mpx_muldiv.sv | 93 +++++++++
 4 files changed

// File: rtl/mpx_muldiv_pkg.sv
// Shared MPX multiply/divide definitions: SPECIAL function codes, divider FSM
// encoding and the HI/LO result pair.
package mpx_muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

endpackage

// File: rtl/mpx_muldiv_if.sv
// Issue and HI/LO writeback bus between the core (master) and the mult/div unit (slave).
interface mpx_muldiv_if;

    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [31:0] opcode_rs_operand_i;
    logic [31:0] opcode_rt_operand_i;
    logic        hold_i;
    logic        busy_o;
    logic        writeback_valid_o;
    logic [31:0] writeback_hi_o;
    logic [31:0] writeback_lo_o;

    modport master (
        output opcode_valid_i, opcode_opcode_i, opcode_rs_operand_i, opcode_rt_operand_i, hold_i,
        input  busy_o, writeback_valid_o, writeback_hi_o, writeback_lo_o
    );

    modport slave (
        input  opcode_valid_i, opcode_opcode_i, opcode_rs_operand_i, opcode_rt_operand_i, hold_i,
        output busy_o, writeback_valid_o, writeback_hi_o, writeback_lo_o
    );

endinterface

// File: rtl/mpx_muldiv_divider.sv
// Radix-2 restoring divider on operand magnitudes; sign fix-up and divide-by-zero
// substitution are applied on the registered result while in DONE.
module mpx_divider
    import mpx_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output hilo_t       result,
    output logic        valid,
    output logic        busy
);

    localparam int               CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      quo_q, rem_q, dsr_q, dvd_q, rem_nx;
    logic [32:0]      rem_sh;
    logic             neg_quo_q, neg_rem_q, dz_q, ge;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = DIV_RUN;
            DIV_RUN:  if (cnt_q == LAST) state_d = DIV_DONE;
            DIV_DONE: state_d = start ? DIV_RUN : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // One quotient bit per cycle: shift the next dividend bit into the partial remainder.
    assign rem_sh = {rem_q, quo_q[31]};
    assign ge     = rem_sh >= {1'b0, dsr_q};
    assign rem_nx = ge ? rem_sh[31:0] - dsr_q : rem_sh[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (!hold) begin
            state_q <= state_d;
            if (start) begin
                quo_q     <= (is_signed && dividend[31]) ? -dividend : dividend;
                dsr_q     <= (is_signed && divisor[31]) ? -divisor : divisor;
                rem_q     <= '0;
                dvd_q     <= dividend;
                dz_q      <= (divisor == '0);
                neg_quo_q <= is_signed && (dividend[31] ^ divisor[31]);
                neg_rem_q <= is_signed && dividend[31];
                cnt_q     <= '0;
            end else if (state_q == DIV_RUN) begin
                quo_q <= {quo_q[30:0], ge};
                rem_q <= rem_nx;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign valid     = (state_q == DIV_DONE);
    assign busy      = (state_q == DIV_RUN);
    assign result.lo = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign result.hi = dz_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);

endmodule

// File: rtl/mpx_muldiv.sv
// MPX HI/LO unit: fully pipelined 33x33 multiplier plus an optional iterative divider,
// present only when MPX_MULDIV_DIV_EN is defined.
module mpx_muldiv
    import mpx_muldiv_pkg::*;
#(
    parameter int MULT_STAGES = 2,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mpx_muldiv_if.slave bus
);

    logic [5:0]             funct;
    logic                   special, is_mul, is_signed, accept, mul_go, busy, div_valid;
    logic                   unused_opcode;
    logic [MULT_STAGES-1:0] vld_pipe;
    logic [63:0]            a_q, b_q, prod, mul_res;
    hilo_t                  wb_q, div_res;

    assign funct         = bus.opcode_opcode_i[5:0];
    assign special       = (bus.opcode_opcode_i[31:26] == OP_SPECIAL);
    assign is_signed     = (funct == FN_MULT) || (funct == FN_DIV);
    assign is_mul        = special && ((funct == FN_MULT) || (funct == FN_MULTU));
    assign unused_opcode = ^bus.opcode_opcode_i[25:6];
    assign accept        = bus.opcode_valid_i && !bus.hold_i && !busy;
    assign mul_go        = accept && is_mul;

`ifdef MPX_MULDIV_DIV_EN
    logic is_div, div_go;

    assign is_div = special && ((funct == FN_DIV) || (funct == FN_DIVU));
    assign div_go = accept && is_div;

    mpx_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk_i),
        .rst       (rst_i),
        .hold      (bus.hold_i),
        .start     (div_go),
        .is_signed (is_signed),
        .dividend  (bus.opcode_rs_operand_i),
        .divisor   (bus.opcode_rt_operand_i),
        .result    (div_res),
        .valid     (div_valid),
        .busy      (busy)
    );
`else
    localparam int unused_div_cycles = DIV_CYCLES;

    assign div_res   = '0;
    assign div_valid = 1'b0;
    assign busy      = 1'b0;
`endif

    // Operands are pre-extended to 64 bits so a plain 64-bit product yields the low word.
    assign prod = a_q * b_q;

    generate
        if (MULT_STAGES == 3) begin : g_mul3
            logic [63:0] prod_q;
            always_ff @(posedge clk_i) begin
                if (rst_i)                           prod_q <= '0;
                else if (!bus.hold_i && vld_pipe[0]) prod_q <= prod;
            end
            assign mul_res = prod_q;
        end else begin : g_mul2
            assign mul_res = prod;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wb_q     <= '0;
        end else if (!bus.hold_i) begin
            vld_pipe <= {vld_pipe[MULT_STAGES-2:0], mul_go};
            if (mul_go) begin
                a_q <= {{32{is_signed & bus.opcode_rs_operand_i[31]}}, bus.opcode_rs_operand_i};
                b_q <= {{32{is_signed & bus.opcode_rt_operand_i[31]}}, bus.opcode_rt_operand_i};
            end
            if (vld_pipe[MULT_STAGES-2]) wb_q <= hilo_t'(mul_res);
            // Latch the divide result on leaving DONE so HI/LO keep it afterwards.
            if (div_valid) wb_q <= div_res;
        end
    end

    assign bus.busy_o            = busy;
    assign bus.writeback_valid_o = vld_pipe[MULT_STAGES-1] | div_valid;
    assign {bus.writeback_hi_o, bus.writeback_lo_o} = div_valid ? div_res : wb_q;

endmodule
